// File: rtl/ram_arbiter_pkg.sv
// Shared constants and tag types for the two-port RAM arbiter.
// Owner encoding doubles as the round-robin "favoured port" value.
package ram_pkg;
    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic is_read;
        logic owner;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, is_read: 1'b0, owner: OWN_A};
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester A/B handshake signals plus the RAM command/data bus.
// slave = arbiter side; master = requesters and the RAM instance.
interface ram_arbiter_if;
    import ram_pkg::*;

    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;

    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;

    logic          ram_cen, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_cen, ram_wen, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_cen, ram_wen, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the port that wins a tie
// and moves to the other port whenever anything is granted.
module rr_arb2
    import ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (req_i[0] && (!req_i[1] || ptr_q == OWN_A)) begin
            gnt_o[0] = 1'b1;
            ptr_d    = OWN_B;
        end else if (req_i[1]) begin
            gnt_o[1] = 1'b1;
            ptr_d    = OWN_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= OWN_A;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin front end for a single-port synchronous RAM: registers the
// winning command, tracks read ownership through a 2-deep tag pipe, returns data.
module ram_arbiter
    import ram_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);
    logic [1:0]    gnt;
    logic          any_gnt, sel_b, win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    logic          cen_q, cen_d, wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    tag_t          tag1_q, tag1_d, tag2_q, tag2_d;
    logic          ret_rd;
    logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({bus.b_req, bus.a_req}),
        .gnt_o (gnt)
    );

    assign bus.a_gnt = gnt[0];
    assign bus.b_gnt = gnt[1];

    assign any_gnt   = |gnt;
    assign sel_b     = gnt[1];
    assign win_we    = sel_b ? bus.b_we    : bus.a_we;
    assign win_addr  = sel_b ? bus.b_addr  : bus.a_addr;
    assign win_wdata = sel_b ? bus.b_wdata : bus.a_wdata;

    always_comb begin
        // addr/din hold on idle cycles so the RAM pins only toggle on real accesses
        cen_d  = any_gnt;
        wen_d  = any_gnt & win_we;
        addr_d = any_gnt ? win_addr  : addr_q;
        din_d  = any_gnt ? win_wdata : din_q;

        tag1_d.valid   = any_gnt;
        tag1_d.is_read = any_gnt & ~win_we;
        tag1_d.owner   = sel_b ? OWN_B : OWN_A;
        tag2_d         = tag1_q;

        ret_rd     = tag2_q.valid & tag2_q.is_read;
        a_rvalid_d = ret_rd & (tag2_q.owner == OWN_A);
        b_rvalid_d = ret_rd & (tag2_q.owner == OWN_B);
        a_rdata_d  = a_rvalid_d ? bus.ram_dout : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? bus.ram_dout : b_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cen_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            tag1_q     <= TAG_NONE;
            tag2_q     <= TAG_NONE;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign bus.ram_cen  = cen_q;
    assign bus.ram_wen  = wen_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: queue-driven requesters, a RAM model, and a
// transaction-level reference checked against the DUT every cycle.
module tb_ram_arbiter;
    import ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] preload(input int i);
        case (i)
            1:       return 32'h0000_0011;
            2:       return 32'h0000_0022;
            5:       return 32'h0000_0055;
            default: return 32'h0;
        endcase
    endfunction

    // RAM: registered read, output 0 whenever not reading
    logic [DW-1:0] mem [32];
    bit            ram_init;
    logic [DW-1:0] dout_q = '0;
    assign bus.ram_dout = dout_q;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= preload(i);
            ram_init <= 1'b1;
            dout_q   <= '0;
        end else if (bus.ram_cen) begin
            if (bus.ram_wen) begin
                mem[bus.ram_addr] <= bus.ram_din;
                dout_q            <= '0;
            end else begin
                dout_q <= mem[bus.ram_addr];
            end
        end else begin
            dout_q <= '0;
        end
    end

    // Requesters: head of each queue is presented until granted
    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t qa[$];
    cmd_t qb[$];

    function automatic cmd_t rd(input int a);
        cmd_t c;
        c.we = 1'b0; c.addr = AW'(a); c.wdata = '0;
        return c;
    endfunction

    function automatic cmd_t wr(input int a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = 1'b1; c.addr = AW'(a); c.wdata = d;
        return c;
    endfunction

    task automatic present();
        if (qa.size() != 0) begin
            bus.a_req = 1'b1; bus.a_we = qa[0].we; bus.a_addr = qa[0].addr; bus.a_wdata = qa[0].wdata;
        end else begin
            bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        end
        if (qb.size() != 0) begin
            bus.b_req = 1'b1; bus.b_we = qb[0].we; bus.b_addr = qb[0].addr; bus.b_wdata = qb[0].wdata;
        end else begin
            bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        end
    endtask

    initial begin
        bit ta, tb;
        present();
        forever begin
            @(negedge clk);
            ta = bus.a_gnt & rst_n;
            tb = bus.b_gnt & rst_n;
            @(posedge clk);
            #1;
            if (ta) void'(qa.pop_front());
            if (tb) void'(qb.pop_front());
            present();
        end
    end

    // Reference: who wins, what the RAM pins show next cycle, and which read
    // data returns to which port three cycles after its grant.
    typedef struct {
        int            due;
        bit            own;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    bit            gseq[$];
    logic [DW-1:0] ref_mem [32];

    initial begin
        int            cyc;
        bit            fav;
        bit            m_cen, m_wen;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_din, m_ard, m_brd;
        bit            eav, ebv, got, win, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        ret_t          r;
        cyc = 0; fav = 1'b0;
        m_cen = 1'b0; m_wen = 1'b0; m_addr = '0; m_din = '0; m_ard = '0; m_brd = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst ram_cen", 32'(bus.ram_cen), 32'd0);
                chk("rst a_rvalid", 32'(bus.a_rvalid), 32'd0);
                chk("rst b_rvalid", 32'(bus.b_rvalid), 32'd0);
                chk("rst a_rdata", bus.a_rdata, 32'd0);
                chk("rst b_rdata", bus.b_rdata, 32'd0);
                fav = 1'b0; m_cen = 1'b0; m_wen = 1'b0; m_addr = '0; m_din = '0;
                m_ard = '0; m_brd = '0;
                rq.delete();
            end else begin
                eav = 1'b0; ebv = 1'b0;
                if (rq.size() != 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    if (r.own) begin ebv = 1'b1; m_brd = r.data; end
                    else       begin eav = 1'b1; m_ard = r.data; end
                end
                chk("ram_cen", 32'(bus.ram_cen), 32'(m_cen));
                chk("ram_wen", 32'(bus.ram_wen), 32'(m_wen));
                chk("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
                chk("ram_din", bus.ram_din, m_din);
                chk("a_rvalid", 32'(bus.a_rvalid), 32'(eav));
                chk("b_rvalid", 32'(bus.b_rvalid), 32'(ebv));
                chk("a_rdata", bus.a_rdata, m_ard);
                chk("b_rdata", bus.b_rdata, m_brd);

                got = 1'b1; win = 1'b0;
                if (bus.a_req && bus.b_req) win = fav;
                else if (bus.a_req)         win = 1'b0;
                else if (bus.b_req)         win = 1'b1;
                else                        got = 1'b0;
                chk("a_gnt", 32'(bus.a_gnt), 32'(got && !win));
                chk("b_gnt", 32'(bus.b_gnt), 32'(got && win));

                if (got) begin
                    we = win ? bus.b_we : bus.a_we;
                    ad = win ? bus.b_addr : bus.a_addr;
                    wd = win ? bus.b_wdata : bus.a_wdata;
                    fav = !win;
                    m_cen = 1'b1; m_wen = we; m_addr = ad; m_din = wd;
                    if (we) ref_mem[ad] = wd;
                    else    rq.push_back('{due: cyc + 3, own: win, data: ref_mem[ad]});
                    gseq.push_back(win);
                end else begin
                    m_cen = 1'b0; m_wen = 1'b0;
                end
            end
            cyc++;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) chk("idle timeout", 32'(qa.size() + qb.size()), 32'd0);
        repeat (6) @(posedge clk);
        #2;
    endtask

    initial begin
        int  n;
        bit  exp_seq[19];
        exp_seq = '{0,1, 0,0, 1,0,0, 0, 1,0, 1, 0,1,0,1,0,1, 0,0};

        // requests held through reset; first grant after release goes to A
        qa.push_back(rd(1));
        qb.push_back(rd(2));
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle();
        chk("seg0 a_rdata", bus.a_rdata, 32'h0000_0011);
        chk("seg0 b_rdata", bus.b_rdata, 32'h0000_0022);

        qa.push_back(wr(3, 32'hDEAD_BEEF));
        qa.push_back(rd(3));
        wait_idle();
        chk("wr-rd a_rdata", bus.a_rdata, 32'hDEAD_BEEF);

        // pointer now favours B: B goes first, A's write waits unchanged
        qa.push_back(wr(10, 32'h0A0A_0A0A));
        qa.push_back(rd(10));
        qb.push_back(rd(2));
        wait_idle();
        chk("held a_rdata", bus.a_rdata, 32'h0A0A_0A0A);
        chk("held b_rdata", bus.b_rdata, 32'h0000_0022);

        qa.push_back(rd(31));
        wait_idle();
        chk("addr31 blank", bus.a_rdata, 32'h0);

        qa.push_back(rd(31));
        qb.push_back(wr(31, 32'hFFFF_FFFF));
        wait_idle();
        chk("addr31 full", bus.a_rdata, 32'hFFFF_FFFF);

        qb.push_back(rd(2));
        wait_idle();

        for (int i = 0; i < 3; i++) begin
            qa.push_back(rd(1));
            qb.push_back(rd(2));
        end
        wait_idle();
        chk("stream a_rdata", bus.a_rdata, 32'h0000_0011);
        chk("stream b_rdata", bus.b_rdata, 32'h0000_0022);

        // reset one cycle after a read grant discards the read
        qa.push_back(rd(5));
        n = 0;
        while (qa.size() != 0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("mid-rst grant", 32'(qa.size()), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("post-rst a_rdata", bus.a_rdata, 32'h0);
        qa.push_back(rd(5));
        wait_idle();
        chk("re-read a_rdata", bus.a_rdata, 32'h0000_0055);

        chk("grant count", 32'(gseq.size()), 32'd19);
        for (int i = 0; i < 19 && i < gseq.size(); i++)
            chk($sformatf("grant[%0d]", i), 32'(gseq[i]), 32'(exp_seq[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
